// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;
   localparam int   BE_NONE = 0;

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection for the two requesters, plus the aging counter and
// last-winner history that steer it.
module dmem_arb_select
   import dmem_arb_pkg::*;
#(
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic i_cpu_req,
   input  logic i_dbg_req,
   input  logic i_idle,
   output logic o_winner,
   output logic o_grant
);

   logic [7:0] r_age_cnt;
   logic       r_last_winner;
   logic       w_aged;
   logic       w_both;

   assign w_both  = i_cpu_req & i_dbg_req;
   assign w_aged  = (r_age_cnt == 8'(MAX_WAIT));
   assign o_grant = i_idle & (i_cpu_req | i_dbg_req);

   always_comb begin
      o_winner = REQ_CPU;
      if (w_both) begin
         if (RR_MODE != 0) begin
            o_winner = ~r_last_winner;
         end else begin
            o_winner = w_aged ? REQ_DBG : REQ_CPU;
         end
      end else if (i_dbg_req) begin
         o_winner = REQ_DBG;
      end
   end

   // Aging only advances on an arbitration the debug port actually lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_age_cnt     <= '0;
         r_last_winner <= REQ_DBG;
      end else begin
         if (o_grant) begin
            r_last_winner <= o_winner;
         end
         if (!i_dbg_req || (o_grant && (o_winner == REQ_DBG))) begin
            r_age_cnt <= '0;
         end else if (o_grant && !w_aged) begin
            r_age_cnt <= r_age_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU memory stage and the
// debug/loader port; one access at a time, RAM-side signals registered.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_wen,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   input  logic [DATA_W/8-1:0]   cpu_be,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_W-1:0]     cpu_rdata,
   input  logic                  dbg_req,
   input  logic                  dbg_wen,
   input  logic [ADDR_W-1:0]     dbg_addr,
   input  logic [DATA_W-1:0]     dbg_wdata,
   input  logic [DATA_W/8-1:0]   dbg_be,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_W-1:0]     dbg_rdata,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wen,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   localparam int BE_W = DATA_W / 8;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_owner;
   logic                r_cpu_gnt;
   logic                r_dbg_gnt;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_wen;
   logic [BE_W-1:0]     r_mem_be;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                w_winner;
   logic                w_grant;
   logic                w_resp;
   logic                w_sel_wen;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic [BE_W-1:0]     w_sel_be;

   dmem_arb_select #(
      .RR_MODE  (RR_MODE),
      .MAX_WAIT (MAX_WAIT)
   ) u_sel (
      .clk       (clk),
      .rst       (rst),
      .i_cpu_req (cpu_req),
      .i_dbg_req (dbg_req),
      .i_idle    (r_state == IDLE),
      .o_winner  (w_winner),
      .o_grant   (w_grant)
   );

   assign w_sel_wen   = (w_winner == REQ_DBG) ? dbg_wen   : cpu_wen;
   assign w_sel_addr  = (w_winner == REQ_DBG) ? dbg_addr  : cpu_addr;
   assign w_sel_wdata = (w_winner == REQ_DBG) ? dbg_wdata : cpu_wdata;
   assign w_sel_be    = (w_winner == REQ_DBG) ? dbg_be    : cpu_be;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A registered write strobe in ACCESS means the access is a store.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_state_next = ACCESS;
         ACCESS:  w_state_next = r_mem_wen ? IDLE : RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner     <= REQ_CPU;
         r_cpu_gnt   <= 1'b0;
         r_dbg_gnt   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wen   <= 1'b0;
         r_mem_be    <= BE_W'(BE_NONE);
         r_mem_wdata <= '0;
      end else begin
         r_cpu_gnt <= 1'b0;
         r_dbg_gnt <= 1'b0;
         if (w_grant) begin
            r_owner    <= w_winner;
            r_cpu_gnt  <= (w_winner == REQ_CPU);
            r_dbg_gnt  <= (w_winner == REQ_DBG);
            r_mem_addr <= w_sel_addr;
            r_mem_wen  <= w_sel_wen;
            r_mem_be   <= w_sel_wen ? w_sel_be : BE_W'(BE_NONE);
            if (w_sel_wen) begin
               r_mem_wdata <= w_sel_wdata;
            end
         end else if (r_state == ACCESS) begin
            r_mem_wen <= 1'b0;
            r_mem_be  <= BE_W'(BE_NONE);
         end
      end
   end

   assign w_resp     = (r_state == RESP);
   assign cpu_rvalid = w_resp & (r_owner == REQ_CPU);
   assign dbg_rvalid = w_resp & (r_owner == REQ_DBG);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

   assign cpu_gnt   = r_cpu_gnt;
   assign dbg_gnt   = r_dbg_gnt;
   assign mem_addr  = r_mem_addr;
   assign mem_wen   = r_mem_wen;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Two arbiters side by side (index 0: fixed priority with aging, MAX_WAIT=3;
// index 1: round-robin), each with its own RAM, checked against a
// transaction-level model every cycle plus directed spot checks.
module tb_dmem_arbiter;

   localparam int MAXW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        cpu_req [2];
   logic        cpu_wen [2];
   logic [31:0] cpu_addr [2];
   logic [31:0] cpu_wdata [2];
   logic [3:0]  cpu_be [2];
   logic        cpu_gnt [2];
   logic        cpu_rvalid [2];
   logic [31:0] cpu_rdata [2];
   logic        dbg_req [2];
   logic        dbg_wen [2];
   logic [31:0] dbg_addr [2];
   logic [31:0] dbg_wdata [2];
   logic [3:0]  dbg_be [2];
   logic        dbg_gnt [2];
   logic        dbg_rvalid [2];
   logic [31:0] dbg_rdata [2];
   logic [31:0] mem_addr [2];
   logic        mem_wen [2];
   logic [3:0]  mem_be [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        busy [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [31:0] ram [16];

      dmem_arbiter #(
         .ADDR_W   (32),
         .DATA_W   (32),
         .RR_MODE  (gi),
         .MAX_WAIT (MAXW)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .cpu_req    (cpu_req[gi]),
         .cpu_wen    (cpu_wen[gi]),
         .cpu_addr   (cpu_addr[gi]),
         .cpu_wdata  (cpu_wdata[gi]),
         .cpu_be     (cpu_be[gi]),
         .cpu_gnt    (cpu_gnt[gi]),
         .cpu_rvalid (cpu_rvalid[gi]),
         .cpu_rdata  (cpu_rdata[gi]),
         .dbg_req    (dbg_req[gi]),
         .dbg_wen    (dbg_wen[gi]),
         .dbg_addr   (dbg_addr[gi]),
         .dbg_wdata  (dbg_wdata[gi]),
         .dbg_be     (dbg_be[gi]),
         .dbg_gnt    (dbg_gnt[gi]),
         .dbg_rvalid (dbg_rvalid[gi]),
         .dbg_rdata  (dbg_rdata[gi]),
         .mem_addr   (mem_addr[gi]),
         .mem_wen    (mem_wen[gi]),
         .mem_be     (mem_be[gi]),
         .mem_wdata  (mem_wdata[gi]),
         .mem_rdata  (mem_rdata[gi]),
         .busy       (busy[gi])
      );

      // Synchronous RAM: read data appears the cycle after the address.
      always @(posedge clk) begin
         if (rst) begin
            for (int w = 0; w < 16; w++) ram[w] <= '0;
            mem_rdata[gi] <= '0;
         end else begin
            if (mem_wen[gi]) begin
               for (int b = 0; b < 4; b++) begin
                  if (mem_be[gi][b]) ram[mem_addr[gi][5:2]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
               end
            end
            mem_rdata[gi] <= ram[mem_addr[gi][5:2]];
         end
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: cycles left in the current access, its kind, owner and data.
   int          m_left [2];
   logic        m_rd [2];
   logic        m_owner [2];
   logic        m_resp [2];
   logic        m_last [2];
   int          m_age [2];
   logic [31:0] m_rdat [2];
   logic [31:0] shadow [2][16];
   logic        e_gc [2];
   logic        e_gd [2];
   logic [31:0] e_addr [2];
   logic [31:0] e_wdata [2];
   logic        e_wen [2];
   logic [3:0]  e_be [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int i);
      logic        win;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [3:0]  idx;
      e_gc[i] = 1'b0;
      e_gd[i] = 1'b0;
      if (rst) begin
         m_left[i] = 0; m_resp[i] = 1'b0; m_last[i] = 1'b1; m_age[i] = 0;
         e_addr[i] = '0; e_wen[i] = 1'b0; e_be[i] = '0; e_wdata[i] = '0;
         for (int k = 0; k < 16; k++) shadow[i][k] = '0;
      end else if (m_left[i] == 0) begin
         m_resp[i] = 1'b0;
         if (cpu_req[i] || dbg_req[i]) begin
            if (cpu_req[i] && dbg_req[i]) win = (i == 1) ? !m_last[i] : (m_age[i] == MAXW);
            else win = dbg_req[i];
            if (dbg_req[i] && !win) m_age[i] = (m_age[i] < MAXW) ? m_age[i] + 1 : MAXW;
            else m_age[i] = 0;
            m_last[i]  = win;
            m_owner[i] = win;
            w  = win ? dbg_wen[i]   : cpu_wen[i];
            a  = win ? dbg_addr[i]  : cpu_addr[i];
            wd = win ? dbg_wdata[i] : cpu_wdata[i];
            be = win ? dbg_be[i]    : cpu_be[i];
            idx = a[5:2];
            e_addr[i] = a;
            e_wen[i]  = w;
            e_be[i]   = w ? be : 4'b0000;
            if (w) begin
               e_wdata[i] = wd;
               for (int b = 0; b < 4; b++) if (be[b]) shadow[i][idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
               m_rdat[i] = shadow[i][idx];
            end
            m_rd[i]   = !w;
            m_left[i] = w ? 1 : 2;
            if (win) e_gd[i] = 1'b1; else e_gc[i] = 1'b1;
            $display("[%0t] inst%0d %s %s addr=%h wdata=%h be=%b", $time, i,
                     win ? "DBG" : "CPU", w ? "WR" : "RD", a, wd, be);
         end else begin
            m_age[i] = 0;
         end
      end else begin
         m_left[i]--;
         if (!dbg_req[i]) m_age[i] = 0;
         if (!m_rd[i]) begin
            e_wen[i] = 1'b0;
            e_be[i]  = 4'b0000;
         end
         m_resp[i] = m_rd[i] && (m_left[i] == 1);
      end
   endtask

   task automatic compare(input int i);
      logic c_rv;
      logic d_rv;
      c_rv = m_resp[i] && !m_owner[i];
      d_rv = m_resp[i] && m_owner[i];
      chk($sformatf("i%0d cpu_gnt", i),    cpu_gnt[i],    e_gc[i]);
      chk($sformatf("i%0d dbg_gnt", i),    dbg_gnt[i],    e_gd[i]);
      chk($sformatf("i%0d gnt_excl", i),   cpu_gnt[i] & dbg_gnt[i], 0);
      chk($sformatf("i%0d mem_addr", i),   mem_addr[i],   e_addr[i]);
      chk($sformatf("i%0d mem_wen", i),    mem_wen[i],    e_wen[i]);
      chk($sformatf("i%0d mem_be", i),     mem_be[i],     e_be[i]);
      chk($sformatf("i%0d mem_wdata", i),  mem_wdata[i],  e_wdata[i]);
      chk($sformatf("i%0d busy", i),       busy[i],       m_left[i] != 0);
      chk($sformatf("i%0d cpu_rvalid", i), cpu_rvalid[i], c_rv);
      chk($sformatf("i%0d dbg_rvalid", i), dbg_rvalid[i], d_rv);
      chk($sformatf("i%0d cpu_rdata", i),  cpu_rdata[i],  c_rv ? m_rdat[i] : 32'h0);
      chk($sformatf("i%0d dbg_rdata", i),  dbg_rdata[i],  d_rv ? m_rdat[i] : 32'h0);
   endtask

   task automatic step();
      for (int i = 0; i < 2; i++) model_edge(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) compare(i);
      for (int i = 0; i < 2; i++) begin
         if (e_gc[i]) cpu_req[i] = 1'b0;
         if (e_gd[i]) dbg_req[i] = 1'b0;
      end
   endtask

   task automatic set_cpu(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      for (int i = 0; i < 2; i++) begin
         cpu_req[i] = 1'b1; cpu_wen[i] = w; cpu_addr[i] = a; cpu_wdata[i] = d; cpu_be[i] = be;
      end
   endtask

   task automatic set_dbg(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      for (int i = 0; i < 2; i++) begin
         dbg_req[i] = 1'b1; dbg_wen[i] = w; dbg_addr[i] = a; dbg_wdata[i] = d; dbg_be[i] = be;
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         cpu_req[i] = 1'b0;
         dbg_req[i] = 1'b0;
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int          rv_at;
   int          rv_cnt;
   logic [31:0] rv_data;
   int          gq0 [$];
   int          gq1 [$];
   int          ageq [$];
   int          exp_rr [4];
   int          exp_age_order [4];
   int          exp_ages [4];

   initial begin
      for (int i = 0; i < 2; i++) begin
         cpu_req[i] = 1'b0; cpu_wen[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0; cpu_be[i] = '0;
         dbg_req[i] = 1'b0; dbg_wen[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0; dbg_be[i] = '0;
         m_left[i] = 0; m_rd[i] = 1'b0; m_owner[i] = 1'b0; m_resp[i] = 1'b0;
         m_last[i] = 1'b1; m_age[i] = 0; m_rdat[i] = '0;
      end
      do_reset();

      // CPU word store to 0x40.
      set_cpu(1'b1, 32'h40, 32'hDEADBEEF, 4'b1111);
      step();
      chk("wr cpu_gnt", cpu_gnt[0], 1);
      chk("wr mem_wen", mem_wen[0], 1);
      chk("wr mem_be", mem_be[0], 4'b1111);
      chk("wr mem_addr", mem_addr[0], 32'h40);
      step();
      chk("wr mem_wen cleared", mem_wen[0], 0);
      chk("wr busy cleared", busy[0], 0);
      step();

      // CPU load of 0x40: rvalid one cycle after the gnt cycle.
      set_cpu(1'b0, 32'h40, 32'h0, 4'b1111);
      rv_at = -1; rv_cnt = 0; rv_data = '0;
      for (int s = 0; s < 4; s++) begin
         step();
         if (s == 0) chk("rd read mem_be", mem_be[0], 4'b0000);
         if (cpu_rvalid[0]) begin rv_at = s; rv_cnt++; rv_data = cpu_rdata[0]; end
         chk("rd dbg_rvalid idle", dbg_rvalid[0], 0);
      end
      chk("rd rvalid count", rv_cnt, 1);
      chk("rd rvalid cycle", rv_at, 1);
      chk("rd rdata", rv_data, 32'hDEADBEEF);

      // Debug byte store to 0x13.
      set_dbg(1'b1, 32'h13, 32'h000000A5, 4'b0001);
      step();
      chk("bs dbg_gnt", dbg_gnt[0], 1);
      chk("bs mem_be", mem_be[0], 4'b0001);
      chk("bs mem_wen", mem_wen[0], 1);
      step();
      chk("bs mem_wen cleared", mem_wen[0], 0);
      step();

      // Both ports hold requests continuously.
      do_reset();
      set_cpu(1'b1, 32'h20, 32'h11112222, 4'b1111);
      set_dbg(1'b1, 32'h24, 32'h33334444, 4'b1111);
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < 2; i++) begin cpu_req[i] = 1'b1; dbg_req[i] = 1'b1; end
         step();
         if (cpu_gnt[0] || dbg_gnt[0]) begin
            gq0.push_back(int'(dbg_gnt[0]));
            ageq.push_back(int'(g_dut[0].u_dut.u_sel.r_age_cnt));
         end
         if (cpu_gnt[1] || dbg_gnt[1]) gq1.push_back(int'(dbg_gnt[1]));
      end
      exp_rr        = '{0, 1, 0, 1};
      exp_age_order = '{0, 0, 0, 1};
      exp_ages      = '{1, 2, 3, 0};
      chk("rr grant count", gq1.size() >= 4, 1);
      chk("age grant count", gq0.size() >= 4, 1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr grant %0d", k), (k < gq1.size()) ? gq1[k] : -1, exp_rr[k]);
         chk($sformatf("age grant %0d", k), (k < gq0.size()) ? gq0[k] : -1, exp_age_order[k]);
         chk($sformatf("age cnt %0d", k), (k < ageq.size()) ? ageq[k] : -1, exp_ages[k]);
      end

      // Reset while a debug read is in ACCESS.
      do_reset();
      set_dbg(1'b0, 32'h10, 32'h0, 4'b1111);
      step();
      chk("mr busy in access", busy[0], 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr busy after rst", busy[0], 0);
      chk("mr mem_addr after rst", mem_addr[0], 0);
      rv_cnt = 0;
      for (int s = 0; s < 4; s++) begin
         step();
         if (dbg_rvalid[0] || dbg_rvalid[1]) rv_cnt++;
      end
      chk("mr no rvalid", rv_cnt, 0);
      set_dbg(1'b1, 32'h10, 32'h12345678, 4'b1111);
      step(); step();
      set_dbg(1'b0, 32'h10, 32'h0, 4'b1111);
      rv_cnt = 0; rv_data = '0;
      for (int s = 0; s < 4; s++) begin
         step();
         if (dbg_rvalid[0]) begin rv_cnt++; rv_data = dbg_rdata[0]; end
      end
      chk("mr fresh rvalid", rv_cnt, 1);
      chk("mr fresh rdata", rv_data, 32'h12345678);

      // Random traffic on both instances.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!cpu_req[i] && ($urandom_range(0, 2) == 0)) begin
               cpu_req[i] = 1'b1; cpu_wen[i] = 1'($urandom_range(0, 1));
               cpu_addr[i] = 32'($urandom_range(0, 255)); cpu_wdata[i] = $urandom;
               cpu_be[i] = 4'($urandom_range(1, 15));
            end
            if (!dbg_req[i] && ($urandom_range(0, 2) == 0)) begin
               dbg_req[i] = 1'b1; dbg_wen[i] = 1'($urandom_range(0, 1));
               dbg_addr[i] = 32'($urandom_range(0, 255)); dbg_wdata[i] = $urandom;
               dbg_be[i] = 4'($urandom_range(1, 15));
            end
         end
         step();
      end
      for (int i = 0; i < 2; i++) begin cpu_req[i] = 1'b0; dbg_req[i] = 1'b0; end
      for (int c = 0; c < 4; c++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
